// File: rtl/standoff_pkg.sv
// rtl/standoff_pkg.sv - shared encodings and helpers for the standoff game sequencer
package standoff_pkg;

  typedef enum logic [3:0] {
    CH_BLANK  = 4'd10,
    CH_RELOAD = 4'd11,
    CH_SHIELD = 4'd12,
    CH_SHOOT  = 4'd13,
    CH_READY  = 4'd14
  } choice_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_REVEAL,
    S_RESOLVE,
    S_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Button bit order is {shoot, shield, reload}
  localparam logic [2:0] BTN_RELOAD = 3'b001;
  localparam logic [2:0] BTN_SHIELD = 3'b010;
  localparam logic [2:0] BTN_SHOOT  = 3'b100;

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == BTN_RELOAD) || (v == BTN_SHIELD) || (v == BTN_SHOOT);
  endfunction

  function automatic choice_t btn_to_choice(input logic [2:0] v);
    case (v)
      BTN_RELOAD: return CH_RELOAD;
      BTN_SHOOT:  return CH_SHOOT;
      default:    return CH_SHIELD;
    endcase
  endfunction

endpackage

// File: rtl/standoff_choice_latch.sv
// rtl/standoff_choice_latch.sv - per-player choice capture with lock, timeout default and display mux
module standoff_choice_latch
  import standoff_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       collect,
  input  logic       timeout,
  input  logic       show_real,
  input  logic [2:0] btn,
  output logic       locked,
  output choice_t    choice,
  output choice_t    dchoice
);

  // A real press in the timeout cycle takes priority over the SHIELD default
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      locked <= 1'b0;
      choice <= CH_SHIELD;
    end else if (collect && !locked) begin
      if (is_one_hot(btn)) begin
        locked <= 1'b1;
        choice <= btn_to_choice(btn);
      end else if (timeout) begin
        locked <= 1'b1;
        choice <= CH_SHIELD;
      end
    end
  end

  always_comb begin
    dchoice = CH_BLANK;
    if (show_real)
      dchoice = choice;
    else if (locked)
      dchoice = CH_READY;
  end

endmodule

// File: rtl/standoff_round_ctrl.sv
// rtl/standoff_round_ctrl.sv - two-player standoff round FSM, shared timer, lives/ammo and resolution
module standoff_round_ctrl
  import standoff_pkg::*;
#(
  parameter logic [1:0]  START_LIVES    = 2'd3,
  parameter logic [1:0]  MAX_AMMO       = 2'd3,
  parameter logic [31:0] CHOICE_TIMEOUT = 32'd500_000_000,
  parameter logic [31:0] REVEAL_CYCLES  = 32'd200_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] p1_btn,
  input  logic [2:0] p2_btn,
  output logic [3:0] p1_dchoice,
  output logic [3:0] p2_dchoice,
  output logic [1:0] p1lives,
  output logic [1:0] p2lives,
  output logic [1:0] p1_ammo,
  output logic [1:0] p2_ammo,
  output logic       game_over,
  output logic [1:0] winner
);

  state_t      state_q, state_d;
  logic [31:0] timer_q;
  logic        lock1, lock2;
  choice_t     c1, c2, d1, d2;
  logic        restart, timeout, show_real, clear_locks;
  logic        fire1, fire2;
  logic [1:0]  l1_n, l2_n, a1_n, a2_n;

  assign restart   = start && (state_q == S_IDLE || state_q == S_OVER);
  assign timeout   = (state_q == S_COLLECT) && (timer_q == CHOICE_TIMEOUT - 32'd1);
  assign show_real = (state_q == S_REVEAL) || (state_q == S_RESOLVE) || (state_q == S_OVER);

  standoff_choice_latch u_p1 (
    .clk(clk), .reset(reset), .clear(clear_locks), .collect(state_q == S_COLLECT),
    .timeout(timeout), .show_real(show_real), .btn(p1_btn),
    .locked(lock1), .choice(c1), .dchoice(d1)
  );

  standoff_choice_latch u_p2 (
    .clk(clk), .reset(reset), .clear(clear_locks), .collect(state_q == S_COLLECT),
    .timeout(timeout), .show_real(show_real), .btn(p2_btn),
    .locked(lock2), .choice(c2), .dchoice(d2)
  );

  // Round outcome, computed from pre-round lives/ammo for both players at once
  always_comb begin
    fire1 = (c1 == CH_SHOOT) && (p1_ammo != 2'd0);
    fire2 = (c2 == CH_SHOOT) && (p2_ammo != 2'd0);
    a1_n  = p1_ammo;
    a2_n  = p2_ammo;
    l1_n  = p1lives;
    l2_n  = p2lives;
    if (c1 == CH_RELOAD)
      a1_n = (p1_ammo == MAX_AMMO) ? p1_ammo : p1_ammo + 2'd1;
    else if (fire1)
      a1_n = p1_ammo - 2'd1;
    if (c2 == CH_RELOAD)
      a2_n = (p2_ammo == MAX_AMMO) ? p2_ammo : p2_ammo + 2'd1;
    else if (fire2)
      a2_n = p2_ammo - 2'd1;
    if (fire1 && c2 != CH_SHIELD && p2lives != 2'd0)
      l2_n = p2lives - 2'd1;
    if (fire2 && c1 != CH_SHIELD && p1lives != 2'd0)
      l1_n = p1lives - 2'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: if (lock1 && lock2) state_d = S_REVEAL;
      S_REVEAL:  if (timer_q == REVEAL_CYCLES - 32'd1) state_d = S_RESOLVE;
      S_RESOLVE: state_d = (l1_n == 2'd0 || l2_n == 2'd0) ? S_OVER : S_COLLECT;
      S_OVER:    if (start) state_d = S_COLLECT;
      default:   state_d = S_IDLE;
    endcase
  end

  assign clear_locks = restart || (state_q == S_RESOLVE && state_d == S_COLLECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= 32'd0;
      p1lives <= START_LIVES;
      p2lives <= START_LIVES;
      p1_ammo <= 2'd0;
      p2_ammo <= 2'd0;
      winner  <= WIN_NONE;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        timer_q <= 32'd0;
      else if (timer_q != '1)
        timer_q <= timer_q + 32'd1;
      if (restart) begin
        p1lives <= START_LIVES;
        p2lives <= START_LIVES;
        p1_ammo <= 2'd0;
        p2_ammo <= 2'd0;
        winner  <= WIN_NONE;
      end else if (state_q == S_RESOLVE) begin
        p1lives <= l1_n;
        p2lives <= l2_n;
        p1_ammo <= a1_n;
        p2_ammo <= a2_n;
        if (l1_n == 2'd0 && l2_n == 2'd0)
          winner <= WIN_DRAW;
        else if (l2_n == 2'd0)
          winner <= WIN_P1;
        else if (l1_n == 2'd0)
          winner <= WIN_P2;
      end
    end
  end

  assign p1_dchoice = d1;
  assign p2_dchoice = d2;
  assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_standoff_round_ctrl.sv
// tb/tb_standoff_round_ctrl.sv - scoreboard bench for standoff_round_ctrl
module tb_standoff_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] p1_btn, p2_btn;
  logic [3:0] p1_dchoice, p2_dchoice;
  logic [1:0] p1lives, p2lives, p1_ammo, p2_ammo, winner;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] d1, d2;
    logic [1:0] l1, l2, a1, a2;
    logic       over;
    logic [1:0] win;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_l1, m_l2, m_a1, m_a2;

  standoff_round_ctrl #(
    .START_LIVES(2'd3), .MAX_AMMO(2'd3),
    .CHOICE_TIMEOUT(32'd8), .REVEAL_CYCLES(32'd4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_btn(p1_btn), .p2_btn(p2_btn),
    .p1_dchoice(p1_dchoice), .p2_dchoice(p2_dchoice),
    .p1lives(p1lives), .p2lives(p2lives),
    .p1_ammo(p1_ammo), .p2_ammo(p2_ammo),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] code_of(input logic [2:0] b);
    case (b)
      3'b001:  return 4'd11;
      3'b100:  return 4'd13;
      default: return 4'd12;
    endcase
  endfunction

  function automatic logic is_real(input logic [3:0] d);
    return (d >= 4'd11) && (d <= 4'd13);
  endfunction

  task automatic model_restart;
    m_l1 = 2'd3; m_l2 = 2'd3; m_a1 = 2'd0; m_a2 = 2'd0;
  endtask

  task automatic push_round(input logic [3:0] c1, input logic [3:0] c2);
    exp_t e;
    logic f1, f2;
    logic [1:0] n_l1, n_l2, n_a1, n_a2;
    f1 = (c1 == 4'd13) && (m_a1 != 0);
    f2 = (c2 == 4'd13) && (m_a2 != 0);
    n_a1 = (c1 == 4'd11) ? ((m_a1 == 3) ? 2'd3 : m_a1 + 2'd1) : (f1 ? m_a1 - 2'd1 : m_a1);
    n_a2 = (c2 == 4'd11) ? ((m_a2 == 3) ? 2'd3 : m_a2 + 2'd1) : (f2 ? m_a2 - 2'd1 : m_a2);
    n_l2 = (f1 && c2 != 4'd12 && m_l2 != 0) ? m_l2 - 2'd1 : m_l2;
    n_l1 = (f2 && c1 != 4'd12 && m_l1 != 0) ? m_l1 - 2'd1 : m_l1;
    m_l1 = n_l1; m_l2 = n_l2; m_a1 = n_a1; m_a2 = n_a2;
    e.d1 = c1; e.d2 = c2;
    e.l1 = n_l1; e.l2 = n_l2; e.a1 = n_a1; e.a2 = n_a2;
    e.over = (n_l1 == 0) || (n_l2 == 0);
    e.win  = e.over ? {n_l1 == 2'd0, n_l2 == 2'd0} : 2'b00;
    sb.push_back(e);
  endtask

  // b==0 leaves that player to the timeout default
  task automatic play(input logic [2:0] b1, input logic [2:0] b2, input bit stagger);
    exp_t e;
    int   n;
    push_round(code_of(b1), code_of(b2));
    if (stagger) begin
      p1_btn = b1;
      tick;
      chk("ready_p1", 32'(p1_dchoice), 14);
      chk("blank_p2", 32'(p2_dchoice), 10);
      p1_btn = 3'b100;
      p2_btn = b2;
      tick;
      p1_btn = 3'b000;
      p2_btn = 3'b000;
      chk("ready_p2", 32'(p2_dchoice), 14);
    end else begin
      p1_btn = b1;
      p2_btn = b2;
      tick;
      p1_btn = 3'b000;
      p2_btn = 3'b000;
    end
    n = 0;
    while (!(is_real(p1_dchoice) && is_real(p2_dchoice)) && n < 40) begin
      tick;
      n++;
    end
    chk("reveal_seen", 32'(n < 40), 1);
    e = sb.pop_front();
    chk("reveal_p1", 32'(p1_dchoice), 32'(e.d1));
    chk("reveal_p2", 32'(p2_dchoice), 32'(e.d2));
    n = 0;
    while (is_real(p1_dchoice) && !game_over && n < 20) begin
      tick;
      n++;
    end
    chk("reveal_len", n, 5);
    chk("p1lives", 32'(p1lives), 32'(e.l1));
    chk("p2lives", 32'(p2lives), 32'(e.l2));
    chk("p1_ammo", 32'(p1_ammo), 32'(e.a1));
    chk("p2_ammo", 32'(p2_ammo), 32'(e.a2));
    chk("game_over", 32'(game_over), 32'(e.over));
    chk("winner", 32'(winner), 32'(e.win));
    if (e.over) begin
      chk("over_p1_code", 32'(p1_dchoice), 32'(e.d1));
      chk("over_p2_code", 32'(p2_dchoice), 32'(e.d2));
    end else begin
      chk("next_blank_p1", 32'(p1_dchoice), 10);
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    model_restart();
    chk("start_l1", 32'(p1lives), 3);
    chk("start_l2", 32'(p2lives), 3);
    chk("start_a1", 32'(p1_ammo), 0);
    chk("start_a2", 32'(p2_ammo), 0);
    chk("start_win", 32'(winner), 0);
    chk("start_over", 32'(game_over), 0);
    chk("start_d1", 32'(p1_dchoice), 10);
    chk("start_d2", 32'(p2_dchoice), 10);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; p1_btn = 3'b000; p2_btn = 3'b000;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_d1", 32'(p1_dchoice), 10);
    chk("rst_d2", 32'(p2_dchoice), 10);
    chk("rst_l1", 32'(p1lives), 3);
    chk("rst_l2", 32'(p2lives), 3);
    chk("rst_a1", 32'(p1_ammo), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_win", 32'(winner), 0);

    do_start();
    play(3'b001, 3'b010, 1'b1);
    play(3'b100, 3'b001, 1'b0);
    play(3'b001, 3'b100, 1'b0);
    play(3'b100, 3'b001, 1'b0);
    play(3'b001, 3'b010, 1'b0);
    play(3'b100, 3'b100, 1'b0);

    p1_btn = 3'b001;
    start  = 1'b0;
    tick;
    p1_btn = 3'b000;
    chk("over_hold", 32'(game_over), 1);
    chk("over_d1_hold", 32'(p1_dchoice), 13);

    do_start();
    p1_btn = 3'b011;
    tick;
    p1_btn = 3'b000;
    chk("nohot_p1", 32'(p1_dchoice), 10);
    play(3'b100, 3'b000, 1'b0);

    play(3'b001, 3'b001, 1'b0);
    play(3'b100, 3'b100, 1'b0);
    play(3'b001, 3'b001, 1'b0);
    play(3'b100, 3'b100, 1'b0);
    play(3'b001, 3'b001, 1'b0);
    play(3'b100, 3'b100, 1'b0);

    do_start();
    play(3'b001, 3'b001, 1'b0);
    p1_btn = 3'b100;
    p2_btn = 3'b100;
    tick;
    p1_btn = 3'b000;
    p2_btn = 3'b000;
    n = 0;
    while (!is_real(p1_dchoice) && n < 40) begin
      tick;
      n++;
    end
    chk("mid_reveal_seen", 32'(n < 40), 1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_d1", 32'(p1_dchoice), 10);
    chk("mid_rst_d2", 32'(p2_dchoice), 10);
    chk("mid_rst_a1", 32'(p1_ammo), 0);
    chk("mid_rst_a2", 32'(p2_ammo), 0);
    chk("mid_rst_l1", 32'(p1lives), 3);
    chk("mid_rst_l2", 32'(p2lives), 3);
    chk("mid_rst_over", 32'(game_over), 0);
    p1_btn = 3'b001;
    tick;
    p1_btn = 3'b000;
    chk("idle_no_lock", 32'(p1_dchoice), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
